aer_link_arbiter: RTL and testbench
===================================

// Module: aer_link_arbiter
// PURPOSE
//  Shares the 10-bit AER input link between two requesters: the ROC encoder (port ENC) and the host/SPI
//  configuration path (port HOST). Each requester gets a one-entry capture slot and a BUSY back-pressure signal.
//  Slots are arbitrated round-robin and driven onto the link with a 4-phase REQ/ACK handshake.
//  The block sits between the encoder's NEXT_INDEX/FOUND_NEXT_INDEX outputs and the AER input controller.
// PARAMETERS
//  ADDR_W        10    AER address width
//  CNT_W         16    width of the saturating completed-event counter
//  TIMEOUT_CYC   1024  ACK wait limit in cycles (used only with AER_ARB_TIMEOUT_EN)
// PORTS
//  CLK           in   1       system clock
//  RST           in   1       asynchronous, active-high reset
//  ENC_REQ       in   1       encoder request (level); a rising edge launches one event
//  ENC_ADDR      in   ADDR_W  encoder address, sampled on the ENC_REQ rising-edge cycle
//  ENC_BUSY      out  1       encoder slot full or its event in flight
//  HOST_REQ      in   1       host request (level); a rising edge launches one event
//  HOST_ADDR     in   ADDR_W  host address, sampled on the HOST_REQ rising-edge cycle
//  HOST_BUSY     out  1       host slot full or its event in flight
//  AERIN_ADDR    out  ADDR_W  address to the AER controller, stable while AERIN_REQ=1
//  AERIN_REQ     out  1       4-phase request
//  AERIN_ACK     in   1       4-phase acknowledge (already synchronous to CLK)
//  EVT_CNT       out  CNT_W   completed events, both requesters; saturates at all-ones
//  OVF_ERR       out  1       sticky: a request edge arrived while its slot was full
//  TIMEOUT_ERR   out  1       sticky ACK-timeout flag (0 without AER_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: all outputs 0, both slots empty, round-robin pointer = ENC, FSM = IDLE.
//   RST is asynchronous; asserting it mid-handshake drops AERIN_REQ at once and discards both slots.
//  Capture: each port holds a registered copy of its REQ.
//   Edge = REQ & ~REQ_d. On an edge with the slot empty, slot <= {1, ADDR}.
//   On an edge with the slot full, the event is dropped and OVF_ERR is set; the slot is unchanged.
//  BUSY_x = slot_x_full | (FSM != IDLE && grant == x). BUSY is registered and rises the cycle after the edge.
//  FSM:
//   IDLE: if any slot is full, pick the owner (see arbitration), set AERIN_ADDR <= slot addr -> REQ.
//   REQ: AERIN_REQ=1; when AERIN_ACK=1 -> REL.
//   REL: AERIN_REQ=0; when AERIN_ACK=0 -> DONE.
//   DONE: clear the granted slot, EVT_CNT += 1 (saturating), flip the pointer -> IDLE.
//  Arbitration: if only one slot is full, it wins. If both are full, the port the pointer names wins.
//   The pointer then moves to the other port, so neither requester can starve the other.
//  Latency: edge at cycle t -> slot full at t+1 -> AERIN_REQ=1 at t+2 (FSM idle).
//   BUSY falls the cycle after DONE. Minimum event period is 4 cycles plus ACK delays.
//  Simultaneous edges on both ports are both captured; ENC is served first after reset.
//  A new edge on port x while x's event is in flight is allowed only after the slot clears.
//   Otherwise it is counted as an overflow.
//  AERIN_ADDR holds its last value in IDLE. AERIN_ACK high while in IDLE is ignored.
//  EVT_CNT and the sticky flags clear only on RST.
// CONFIGURATION
//  AER_ARB_TIMEOUT_EN defined:
//   A counter runs in REQ; when it reaches TIMEOUT_CYC with no ACK:
//    - AERIN_REQ drops, TIMEOUT_ERR is set, the FSM goes to DONE;
//    - the slot clears and EVT_CNT is NOT incremented.
//  Not defined: REQ waits for ACK indefinitely; TIMEOUT_ERR is tied to 0 and there is no counter logic.
// TESTING
//  1. ENC_REQ rises with ENC_ADDR=0x1FF, ACK is returned 3 cycles after REQ ->
//     AERIN_REQ=1 at t+2, AERIN_ADDR=0x1FF, EVT_CNT=1, ENC_BUSY falls after ACK drops.
//  2. ENC and HOST edges in the same cycle (0x005, 0x200) -> link order 0x005 then 0x200;
//     a repeat of the same pair then runs in order 0x005, 0x200 again, since the pointer alternates.
//  3. Second ENC edge while ENC_BUSY=1 -> OVF_ERR=1, only the first address appears on the link.
//  4. RST pulse while AERIN_REQ=1 -> AERIN_REQ=0 in the same cycle, BUSY=0, EVT_CNT=0, FSM=IDLE.
//  5. Preload EVT_CNT to 0xFFFE via 2 events plus a forced value, then 3 events -> EVT_CNT holds at 0xFFFF.
//  6. AER_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, ACK never rises -> AERIN_REQ drops at 16 cycles,
//     TIMEOUT_ERR=1, EVT_CNT unchanged, next slot served.

Source files
------------

// File: rtl/aer_link_arbiter_if.sv
// rtl/aer_link_arbiter_if.sv - request/link/status bundle for aer_link_arbiter
//
// Purpose: groups the two requester ports (ENC, HOST), the 4-phase AER link
// and the status outputs of aer_link_arbiter into one interface.
// Modports:
//   slave  - the arbiter's view (samples requests and ACK, drives BUSY/link/status)
//   master - the environment's view (drives requests and ACK)
// Signals:
//   ENC_REQ/ENC_ADDR/ENC_BUSY     encoder requester
//   HOST_REQ/HOST_ADDR/HOST_BUSY  host/SPI requester
//   AERIN_ADDR/AERIN_REQ/AERIN_ACK  4-phase link to the AER input controller
//   EVT_CNT/OVF_ERR/TIMEOUT_ERR   completed-event counter and sticky error flags
interface aer_link_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
);
  logic              ENC_REQ;
  logic [ADDR_W-1:0] ENC_ADDR;
  logic              ENC_BUSY;
  logic              HOST_REQ;
  logic [ADDR_W-1:0] HOST_ADDR;
  logic              HOST_BUSY;
  logic [ADDR_W-1:0] AERIN_ADDR;
  logic              AERIN_REQ;
  logic              AERIN_ACK;
  logic [CNT_W-1:0]  EVT_CNT;
  logic              OVF_ERR;
  logic              TIMEOUT_ERR;

  modport slave (
    input  ENC_REQ, ENC_ADDR, HOST_REQ, HOST_ADDR, AERIN_ACK,
    output ENC_BUSY, HOST_BUSY, AERIN_ADDR, AERIN_REQ, EVT_CNT, OVF_ERR, TIMEOUT_ERR
  );

  modport master (
    output ENC_REQ, ENC_ADDR, HOST_REQ, HOST_ADDR, AERIN_ACK,
    input  ENC_BUSY, HOST_BUSY, AERIN_ADDR, AERIN_REQ, EVT_CNT, OVF_ERR, TIMEOUT_ERR
  );
endinterface

// File: rtl/aer_link_arbiter.sv
// rtl/aer_link_arbiter.sv - round-robin sharing of the AER input link between encoder and host
//
// Purpose: each requester (ENC, HOST) owns a one-entry capture slot filled on
// the rising edge of its REQ level. Full slots are granted round-robin and
// driven onto the AER link with a 4-phase REQ/ACK handshake.
// Ports:
//   CLK  - system clock
//   RST  - asynchronous active-high reset; drops AERIN_REQ at once, empties both slots
//   bus  - aer_link_arbiter_if.slave: ENC_*/HOST_* requesters, AERIN_* link,
//          EVT_CNT (saturating), OVF_ERR and TIMEOUT_ERR sticky flags
// Configuration:
//   AER_ARB_TIMEOUT_EN - when defined, a REQ phase that sees no ACK for
//   TIMEOUT_CYC cycles is abandoned (TIMEOUT_ERR set, slot cleared, not counted).
//   When undefined, REQ waits for ACK forever and TIMEOUT_ERR is tied low.
module aer_link_arbiter #(
  parameter int ADDR_W      = 10,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic             CLK,
  input logic             RST,
  aer_link_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              enc_req_d, host_req_d;
  logic              enc_full, host_full;
  logic [ADDR_W-1:0] enc_slot, host_slot;
  logic [ADDR_W-1:0] link_addr;
  logic              grant;      // 0 = ENC, 1 = HOST
  logic              ptr;        // round-robin preference when both slots are full
  logic              pick;
  logic              enc_edge, host_edge;
  logic [CNT_W-1:0]  evt_cnt;
  logic              ovf_err;
  logic              tmo_fire;   // REQ phase abandoned this cycle
  logic              tmo_hit;    // current DONE follows a timeout, so it is not counted

  assign enc_edge  = bus.ENC_REQ  & ~enc_req_d;
  assign host_edge = bus.HOST_REQ & ~host_req_d;

  // A lone full slot wins outright; the pointer only breaks ties.
  assign pick = (enc_full & host_full) ? ptr : host_full;

`ifdef AER_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_err;

  // ACK wins over a timeout that expires in the same cycle.
  assign tmo_fire = (state == S_REQ) && !bus.AERIN_ACK && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_cnt <= '0;
      tmo_hit <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == S_REQ) ? tmo_cnt + 1'b1 : '0;
      if (tmo_fire) begin
        tmo_hit <= 1'b1;
        tmo_err <= 1'b1;
      end else if (state == S_DONE) begin
        tmo_hit <= 1'b0;
      end
    end
  end

  assign bus.TIMEOUT_ERR = tmo_err;
`else
  assign tmo_fire        = 1'b0;
  assign tmo_hit         = 1'b0;
  assign bus.TIMEOUT_ERR = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enc_full | host_full) state_nxt = S_REQ;
      S_REQ: begin
        if (bus.AERIN_ACK)  state_nxt = S_REL;
        else if (tmo_fire)  state_nxt = S_DONE;
      end
      S_REL:  if (!bus.AERIN_ACK) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.AERIN_REQ = (state == S_REQ);
    bus.ENC_BUSY  = enc_full  | ((state != S_IDLE) && (grant == 1'b0));
    bus.HOST_BUSY = host_full | ((state != S_IDLE) && (grant == 1'b1));
  end

  assign bus.AERIN_ADDR = link_addr;
  assign bus.EVT_CNT    = evt_cnt;
  assign bus.OVF_ERR    = ovf_err;

  // Capture slots, grant, counter and flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      enc_req_d  <= 1'b0;
      host_req_d <= 1'b0;
      enc_full   <= 1'b0;
      host_full  <= 1'b0;
      enc_slot   <= '0;
      host_slot  <= '0;
      link_addr  <= '0;
      grant      <= 1'b0;
      ptr        <= 1'b0;
      evt_cnt    <= '0;
      ovf_err    <= 1'b0;
    end else begin
      enc_req_d  <= bus.ENC_REQ;
      host_req_d <= bus.HOST_REQ;

      // The granted slot stays full until DONE, so an edge during its
      // handshake lands in the overflow branch.
      if ((state == S_DONE) && (grant == 1'b0)) begin
        enc_full <= 1'b0;
      end else if (enc_edge && !enc_full) begin
        enc_full <= 1'b1;
        enc_slot <= bus.ENC_ADDR;
      end

      if ((state == S_DONE) && (grant == 1'b1)) begin
        host_full <= 1'b0;
      end else if (host_edge && !host_full) begin
        host_full <= 1'b1;
        host_slot <= bus.HOST_ADDR;
      end

      if ((enc_edge && enc_full) || (host_edge && host_full)) ovf_err <= 1'b1;

      if ((state == S_IDLE) && (enc_full | host_full)) begin
        grant     <= pick;
        link_addr <= pick ? host_slot : enc_slot;
      end

      if (state == S_DONE) begin
        ptr <= ~ptr;
        if (!tmo_hit && (evt_cnt != {CNT_W{1'b1}})) evt_cnt <= evt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aer_link_arbiter.sv
// tb/tb_aer_link_arbiter.sv - self-checking bench for aer_link_arbiter
module tb_aer_link_arbiter;

  localparam int ADDR_W  = 10;
  localparam int CNT_W   = 4;
  localparam int TMO     = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  aer_link_arbiter_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  aer_link_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: expected link order, pointer, counter and sticky flags
  logic [ADDR_W-1:0] exp_q[$];
  int  exp_cnt = 0;
  bit  exp_ovf = 0;
  bit  exp_ptr = 0;
  bit  exp_tmo = 0;

  // ACK responder and link monitor state
  int  ack_dly = 1, rel_dly = 1;
  bit  ack_en = 1;
  int  req_cnt = 0, rel_cnt = 0, req_hi = 0;
  bit  prev_req = 0, prev_busy = 0;
  int  ack_drop_cyc = 0, busy_fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_event(input logic [ADDR_W-1:0] a, input bit counts);
    exp_q.push_back(a);
    exp_ptr = ~exp_ptr;
    if (counts && exp_cnt < CNT_MAX) exp_cnt++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    if (bus.AERIN_REQ && !prev_req) begin
      if (exp_q.size() == 0) check("unexpected_req", exp_q.size(), 1);
      else check("link_addr", bus.AERIN_ADDR, exp_q.pop_front());
      req_hi = 0;
    end
    if (bus.AERIN_REQ) req_hi++;
    prev_req = bus.AERIN_REQ;
    if (prev_busy && !(bus.ENC_BUSY || bus.HOST_BUSY)) busy_fall_cyc = cyc;
    prev_busy = bus.ENC_BUSY || bus.HOST_BUSY;
    if (bus.AERIN_REQ && !bus.AERIN_ACK && ack_en) begin
      req_cnt++;
      if (req_cnt >= ack_dly) begin
        bus.AERIN_ACK = 1'b1;
        req_cnt = 0;
      end
    end else if (!bus.AERIN_REQ && bus.AERIN_ACK) begin
      rel_cnt++;
      if (rel_cnt >= rel_dly) begin
        bus.AERIN_ACK = 1'b0;
        rel_cnt = 0;
        ack_drop_cyc = cyc;
      end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((bus.ENC_BUSY || bus.HOST_BUSY || bus.AERIN_REQ || bus.AERIN_ACK) && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, 32'(n < 300), 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    check({tag, "_evt_cnt"}, bus.EVT_CNT, exp_cnt);
    check({tag, "_ovf_err"}, bus.OVF_ERR, exp_ovf);
    check({tag, "_timeout_err"}, bus.TIMEOUT_ERR, exp_tmo);
  endtask

  // One round from an idle link: edges on the selected ports in the same
  // cycle, optional repeat edges while the slot is still full, then drain.
  task automatic run_round(input string tag, input bit de, input bit dh,
                           input logic [ADDR_W-1:0] ea, input logic [ADDR_W-1:0] ha,
                           input bit oe, input bit oh, input int ad, input int rd);
    bit first_host;
    ack_dly = ad;
    rel_dly = rd;
    first_host = (de && dh) ? exp_ptr : dh;
    if (de || dh) model_event(first_host ? ha : ea, 1'b1);
    if (de && dh) model_event(first_host ? ea : ha, 1'b1);

    bus.ENC_REQ   = de;
    bus.HOST_REQ  = dh;
    bus.ENC_ADDR  = ea;
    bus.HOST_ADDR = ha;
    tick();
    check({tag, "_enc_busy_rise"}, bus.ENC_BUSY, de);
    check({tag, "_host_busy_rise"}, bus.HOST_BUSY, dh);
    check({tag, "_req_not_early"}, bus.AERIN_REQ, 0);
    bus.ENC_REQ   = 1'b0;
    bus.HOST_REQ  = 1'b0;
    bus.ENC_ADDR  = ADDR_W'($urandom);
    bus.HOST_ADDR = ADDR_W'($urandom);
    tick();
    check({tag, "_req_latency"}, bus.AERIN_REQ, de | dh);
    if (oe || oh) begin
      bus.ENC_REQ  = oe;
      bus.HOST_REQ = oh;
      tick();
      bus.ENC_REQ  = 1'b0;
      bus.HOST_REQ = 1'b0;
      exp_ovf = 1'b1;
    end
    drain(tag);
    if (de ^ dh) check({tag, "_busy_fall_after_ack"}, busy_fall_cyc - ack_drop_cyc, 2);
  endtask

  initial begin
    RST           = 1'b1;
    bus.ENC_REQ   = 1'b0;
    bus.HOST_REQ  = 1'b0;
    bus.ENC_ADDR  = '0;
    bus.HOST_ADDR = '0;
    bus.AERIN_ACK = 1'b0;
    tick();
    tick();
    check("rst_aerin_req", bus.AERIN_REQ, 0);
    check("rst_aerin_addr", bus.AERIN_ADDR, 0);
    check("rst_enc_busy", bus.ENC_BUSY, 0);
    check("rst_host_busy", bus.HOST_BUSY, 0);
    check("rst_evt_cnt", bus.EVT_CNT, 0);
    check("rst_ovf_err", bus.OVF_ERR, 0);
    check("rst_timeout_err", bus.TIMEOUT_ERR, 0);
    RST = 1'b0;
    tick();

    run_round("single_enc", 1'b1, 1'b0, 10'h1FF, 10'h000, 1'b0, 1'b0, 3, 1);
    check("single_enc_link_addr_hold", bus.AERIN_ADDR, 10'h1FF);
    run_round("pair_a", 1'b1, 1'b1, 10'h005, 10'h200, 1'b0, 1'b0, 2, 1);
    run_round("pair_b", 1'b1, 1'b1, 10'h005, 10'h200, 1'b0, 1'b0, 1, 2);
    run_round("enc_overflow", 1'b1, 1'b0, 10'h0AA, 10'h000, 1'b1, 1'b0, 2, 2);

    // Reset in the middle of a handshake
    ack_en = 1'b0;
    exp_q.push_back(10'h123);
    bus.ENC_REQ  = 1'b1;
    bus.ENC_ADDR = 10'h123;
    tick();
    bus.ENC_REQ = 1'b0;
    tick();
    tick();
    check("pre_rst_req_high", bus.AERIN_REQ, 1);
    RST = 1'b1;
    #1;
    check("mid_rst_req_drop", bus.AERIN_REQ, 0);
    check("mid_rst_enc_busy", bus.ENC_BUSY, 0);
    check("mid_rst_evt_cnt", bus.EVT_CNT, 0);
    check("mid_rst_ovf_err", bus.OVF_ERR, 0);
    exp_q.delete();
    exp_cnt = 0;
    exp_ovf = 1'b0;
    exp_ptr = 1'b0;
    exp_tmo = 1'b0;
    ack_en  = 1'b1;
    req_cnt = 0;
    rel_cnt = 0;
    bus.AERIN_ACK = 1'b0;
    tick();
    RST = 1'b0;
    tick();
    tick();
    check("post_rst_link_idle", bus.AERIN_REQ, 0);
    prev_req = 1'b0;

`ifdef AER_ARB_TIMEOUT_EN
    begin
      bit first_host;
      int n = 0;
      int cnt_before;
      ack_en = 1'b0;
      cnt_before = exp_cnt;
      first_host = exp_ptr;
      model_event(first_host ? 10'h311 : 10'h0F0, 1'b0);
      model_event(first_host ? 10'h0F0 : 10'h311, 1'b1);
      bus.ENC_REQ   = 1'b1;
      bus.HOST_REQ  = 1'b1;
      bus.ENC_ADDR  = 10'h0F0;
      bus.HOST_ADDR = 10'h311;
      tick();
      bus.ENC_REQ  = 1'b0;
      bus.HOST_REQ = 1'b0;
      tick();
      while (bus.AERIN_REQ && n < 100) begin
        tick();
        n++;
      end
      check("tmo_req_cycles", req_hi, TMO);
      check("tmo_flag", bus.TIMEOUT_ERR, 1);
      check("tmo_cnt_unchanged", bus.EVT_CNT, cnt_before);
      exp_tmo = 1'b1;
      ack_en  = 1'b1;
      ack_dly = 1;
      rel_dly = 1;
      drain("tmo_next_served");
    end
`endif

    for (int r = 0; r < 40; r++) begin
      bit de, dh, oe, oh;
      de = 1'($urandom);
      dh = 1'($urandom);
      if (!de && !dh) de = 1'b1;
      oe = de && ($urandom_range(3) == 0);
      oh = dh && ($urandom_range(3) == 0);
      run_round("rand", de, dh, ADDR_W'($urandom), ADDR_W'($urandom), oe, oh,
                int'($urandom_range(4, 1)), int'($urandom_range(3, 1)));
    end
    check("evt_cnt_saturated", bus.EVT_CNT, CNT_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
